// File: rtl/elevator_pkg.sv
// elevator_pkg: shared constants and types for the elevator hall-call path
package elevator_pkg;
  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W = 3;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
  localparam logic [1:0] DISPATCH_ELEV_1 = 2'b10;
  localparam logic [1:0] DISPATCH_ELEV_2 = 2'b01;
  typedef enum logic [1:0] {IDLE, LOOKUP, ISSUE} sched_state_t;
endpackage

// File: rtl/hall_call_picker.sv
// hall_call_picker: round-robin first-set finder over the pending slots, starting at rr_ptr
module hall_call_picker #(
  parameter int SLOTS = 16,
  parameter int SLOT_W = 4
) (
  input  logic [SLOTS-1:0]  pend,
  input  logic [SLOT_W-1:0] rr_ptr,
  output logic              found,
  output logic [SLOT_W-1:0] slot
);
  localparam int FULL = 2 ** SLOT_W;
  logic [FULL-1:0] pend_x;
  logic [SLOT_W-1:0] idx;
  assign pend_x = FULL'(pend);
  // scan farthest-first so the nearest set slot at or after rr_ptr wins
  always_comb begin
    found = 1'b0;
    slot = '0;
    idx = '0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      idx = SLOT_W'((int'(rr_ptr) + k) % SLOTS);
      if (pend_x[idx]) begin
        found = 1'b1;
        slot = idx;
      end
    end
  end
endmodule

// File: rtl/hall_call_scheduler.sv
// hall_call_scheduler: latches hall calls and serialises them through the dispatcher to two cars
module hall_call_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W = elevator_pkg::FLOOR_W,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] hall_up_btn,
  input  logic [NUM_FLOORS-1:0] hall_dn_btn,
  output logic [NUM_FLOORS-1:0] hall_up_lamp,
  output logic [NUM_FLOORS-1:0] hall_dn_lamp,
  output logic [FLOOR_W-1:0]    request_floor,
  output logic                  request_dir,
  input  logic [1:0]            dispatch_elev,
  output logic                  assign_valid_1,
  output logic                  assign_valid_2,
  output logic [FLOOR_W-1:0]    assign_floor,
  output logic                  assign_dir,
  input  logic                  assign_ready_1,
  input  logic                  assign_ready_2,
  output logic                  busy
);
  localparam int SLOTS = 2 * NUM_FLOORS;
  localparam int SLOT_W = FLOOR_W + 1;
  localparam int CNT_W = $clog2(WAIT_TIMEOUT);
  localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS - 1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS - 1){1'b1}}, 1'b0};
  sched_state_t state;
  logic [NUM_FLOORS-1:0] up_pend, dn_pend, up_clr, dn_clr;
  logic [SLOTS-1:0] pend;
  logic [SLOT_W-1:0] rr_ptr, pick_slot, cur_slot, next_slot;
  logic [FLOOR_W-1:0] req_floor;
  logic [CNT_W-1:0] wait_cnt;
  logic req_dir, found, target, hs, timeout, legal;
  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_slot
    assign pend[2*i+1] = up_pend[i];
    assign pend[2*i] = dn_pend[i];
  end
  hall_call_picker #(.SLOTS(SLOTS), .SLOT_W(SLOT_W)) u_picker (
    .pend(pend),
    .rr_ptr(rr_ptr),
    .found(found),
    .slot(pick_slot)
  );
  assign cur_slot = {req_floor, req_dir};
  assign next_slot = (cur_slot == SLOT_W'(SLOTS - 1)) ? '0 : cur_slot + 1'b1;
  assign legal = dispatch_elev == DISPATCH_ELEV_1 || dispatch_elev == DISPATCH_ELEV_2;
  // ready from the car not being offered the call never completes a handshake
  assign hs = state == ISSUE && (target ? assign_ready_2 : assign_ready_1);
  assign timeout = state == ISSUE && !hs && wait_cnt == CNT_W'(WAIT_TIMEOUT - 1);
  assign up_clr = (hs && req_dir == DIR_UP) ? NUM_FLOORS'(1) << req_floor : '0;
  assign dn_clr = (hs && req_dir == DIR_DN) ? NUM_FLOORS'(1) << req_floor : '0;
  assign hall_up_lamp = up_pend;
  assign hall_dn_lamp = dn_pend;
  assign request_floor = req_floor;
  assign request_dir = req_dir;
  assign assign_floor = req_floor;
  assign assign_dir = req_dir;
  assign assign_valid_1 = state == ISSUE && !target;
  assign assign_valid_2 = state == ISSUE && target;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      up_pend <= '0;
      dn_pend <= '0;
      rr_ptr <= '0;
      req_floor <= '0;
      req_dir <= 1'b0;
      wait_cnt <= '0;
      target <= 1'b0;
    end else begin
      // a press on the slot being handed over loses to the clear: the car already owns it
      up_pend <= (up_pend | (hall_up_btn & UP_MASK)) & ~up_clr;
      dn_pend <= (dn_pend | (hall_dn_btn & DN_MASK)) & ~dn_clr;
      case (state)
        IDLE: if (found) begin
          req_floor <= pick_slot[SLOT_W-1:1];
          req_dir <= pick_slot[0];
          state <= LOOKUP;
        end
        LOOKUP: begin
          wait_cnt <= '0;
          target <= dispatch_elev == DISPATCH_ELEV_2;
          state <= legal ? ISSUE : IDLE;
          if (!legal) rr_ptr <= next_slot;
        end
        ISSUE: if (hs) begin
          rr_ptr <= next_slot;
          state <= IDLE;
        end else if (timeout) begin
          rr_ptr <= cur_slot;
          state <= IDLE;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hall_call_scheduler.sv
// tb_hall_call_scheduler: table-driven single calls plus hand-written corner sequences, handshakes scoreboarded
module tb_hall_call_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] hall_up_btn, hall_dn_btn, hall_up_lamp, hall_dn_lamp;
  logic [2:0] request_floor, assign_floor;
  logic request_dir, assign_dir, assign_valid_1, assign_valid_2, assign_ready_1, assign_ready_2, busy;
  logic [1:0] dispatch_elev;
  typedef struct {int car; int floor; logic dir;} exp_t;
  typedef struct {int floor; logic dir; logic [1:0] disp; logic v1; logic v2;} vec_t;
  exp_t sb[$];
  exp_t want;
  vec_t vecs[6];
  int n_cmp = 0;
  int n_bad = 0;
  int cnt;
  always #5 clk = ~clk;
  hall_call_scheduler #(.NUM_FLOORS(8), .FLOOR_W(3), .WAIT_TIMEOUT(4)) dut (
    .clk(clk),
    .rst(rst),
    .hall_up_btn(hall_up_btn),
    .hall_dn_btn(hall_dn_btn),
    .hall_up_lamp(hall_up_lamp),
    .hall_dn_lamp(hall_dn_lamp),
    .request_floor(request_floor),
    .request_dir(request_dir),
    .dispatch_elev(dispatch_elev),
    .assign_valid_1(assign_valid_1),
    .assign_valid_2(assign_valid_2),
    .assign_floor(assign_floor),
    .assign_dir(assign_dir),
    .assign_ready_1(assign_ready_1),
    .assign_ready_2(assign_ready_2),
    .busy(busy)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic logic lamp(input int f, input logic d);
    return d ? hall_up_lamp[f] : hall_dn_lamp[f];
  endfunction
  task automatic press(input int f, input logic d);
    if (d) hall_up_btn[f] = 1'b1;
    else hall_dn_btn[f] = 1'b1;
  endtask
  task automatic expect_call(input int car, input int f, input logic d);
    exp_t e;
    e.car = car;
    e.floor = f;
    e.dir = d;
    sb.push_back(e);
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic release_btns();
    hall_up_btn = '0;
    hall_dn_btn = '0;
  endtask
  task automatic drain();
    step();
    dispatch_elev = 2'b10;
    assign_ready_1 = 1'b1;
    assign_ready_2 = 1'b1;
    for (int i = 0; i < 60 && (busy || |hall_up_lamp || |hall_dn_lamp); i++) @(negedge clk);
    @(negedge clk);
    chk("drain_idle", {busy, hall_up_lamp, hall_dn_lamp}, 0);
    chk("sb_empty", sb.size(), 0);
  endtask
  task automatic pulse_rst();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic run_vec(input vec_t v);
    step();
    dispatch_elev = v.disp;
    assign_ready_1 = 1'b1;
    assign_ready_2 = 1'b1;
    press(v.floor, v.dir);
    expect_call(v.v2 ? 2 : 1, v.floor, v.dir);
    step();
    release_btns();
    @(negedge clk);
    chk("vec_lamp_on", lamp(v.floor, v.dir), 1);
    @(negedge clk);
    chk("vec_req_floor", request_floor, v.floor);
    chk("vec_req_dir", request_dir, v.dir);
    chk("vec_busy", busy, 1);
    @(negedge clk);
    chk("vec_valid", {assign_valid_1, assign_valid_2}, {v.v1, v.v2});
    if (v.v1 || v.v2) chk("vec_assign", {assign_floor, assign_dir}, {v.floor[2:0], v.dir});
    @(negedge clk);
    chk("vec_lamp_after", lamp(v.floor, v.dir), !(v.v1 || v.v2));
    drain();
  endtask
  always @(negedge clk) begin
    if (!rst && ((assign_valid_1 && assign_ready_1) || (assign_valid_2 && assign_ready_2))) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: handshake car %0d floor %0d, want no handshake", assign_valid_1 ? 1 : 2, assign_floor);
      end else begin
        want = sb.pop_front();
        chk("sb_car", assign_valid_1 ? 1 : 2, want.car);
        chk("sb_floor", assign_floor, want.floor);
        chk("sb_dir", assign_dir, want.dir);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0] = '{3, 1'b1, 2'b10, 1'b1, 1'b0};
    vecs[1] = '{6, 1'b0, 2'b01, 1'b0, 1'b1};
    vecs[2] = '{0, 1'b1, 2'b01, 1'b0, 1'b1};
    vecs[3] = '{7, 1'b0, 2'b10, 1'b1, 1'b0};
    vecs[4] = '{4, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[5] = '{2, 1'b1, 2'b11, 1'b0, 1'b0};
    rst = 1'b1;
    release_btns();
    dispatch_elev = 2'b00;
    assign_ready_1 = 1'b0;
    assign_ready_2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_lamps", {hall_up_lamp, hall_dn_lamp}, 0);
    chk("rst_req", {request_floor, request_dir}, 0);
    chk("rst_assign", {assign_valid_1, assign_valid_2, assign_floor, assign_dir}, 0);
    chk("rst_busy", busy, 0);
    step();
    rst = 1'b0;
    hall_up_btn = 8'hFF;
    step();
    release_btns();
    @(negedge clk);
    chk("ff_up_lamp", hall_up_lamp, 8'h7F);
    chk("ff_dn_lamp", hall_dn_lamp, 8'h00);
    pulse_rst();
    @(negedge clk);
    chk("rst_clears", {busy, hall_up_lamp, hall_dn_lamp}, 0);
    foreach (vecs[i]) run_vec(vecs[i]);
    // round-robin: 0 up, 2 up, 5 down, then 1 up arriving late waits for the wrap
    pulse_rst();
    dispatch_elev = 2'b10;
    assign_ready_1 = 1'b1;
    assign_ready_2 = 1'b0;
    expect_call(1, 0, 1'b1);
    expect_call(1, 2, 1'b1);
    expect_call(1, 5, 1'b0);
    step();
    press(0, 1'b1);
    press(2, 1'b1);
    press(5, 1'b0);
    step();
    release_btns();
    for (int i = 0; i < 40 && sb.size() > 1; i++) @(negedge clk);
    step();
    expect_call(1, 1, 1'b1);
    press(1, 1'b1);
    step();
    release_btns();
    drain();
    // timeout on car 2, then re-dispatch to car 1
    dispatch_elev = 2'b01;
    assign_ready_1 = 1'b0;
    assign_ready_2 = 1'b0;
    step();
    press(4, 1'b1);
    step();
    release_btns();
    repeat (3) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (!assign_valid_2) break;
      cnt++;
      @(negedge clk);
    end
    chk("timeout_cycles", cnt, 4);
    chk("timeout_lamp_kept", hall_up_lamp[4], 1);
    step();
    dispatch_elev = 2'b10;
    assign_ready_1 = 1'b1;
    expect_call(1, 4, 1'b1);
    drain();
    // reset while an offer is outstanding
    assign_ready_1 = 1'b0;
    assign_ready_2 = 1'b0;
    step();
    press(5, 1'b1);
    step();
    release_btns();
    repeat (3) @(negedge clk);
    chk("midrst_valid_before", assign_valid_1, 1);
    pulse_rst();
    @(negedge clk);
    chk("midrst_cleared", {assign_valid_1, assign_valid_2, busy, hall_up_lamp, hall_dn_lamp}, 0);
    // same-slot press held through the handshake edge, plus another slot pressed then
    dispatch_elev = 2'b10;
    assign_ready_1 = 1'b1;
    expect_call(1, 3, 1'b0);
    step();
    press(3, 1'b0);
    step();
    step();
    step();
    press(6, 1'b1);
    expect_call(1, 6, 1'b1);
    @(negedge clk);
    chk("same_slot_valid", assign_valid_1, 1);
    step();
    release_btns();
    @(negedge clk);
    chk("same_slot_cleared", hall_dn_lamp[3], 0);
    chk("other_slot_kept", hall_up_lamp[6], 1);
    drain();
    // ready from the wrong car is ignored
    dispatch_elev = 2'b01;
    assign_ready_1 = 1'b1;
    assign_ready_2 = 1'b0;
    step();
    press(1, 1'b0);
    step();
    release_btns();
    repeat (3) @(negedge clk);
    chk("wrong_car_offer", {assign_valid_1, assign_valid_2}, 2'b01);
    step();
    @(negedge clk);
    chk("wrong_car_ignored", {assign_valid_1, assign_valid_2, hall_dn_lamp[1]}, 3'b011);
    step();
    assign_ready_2 = 1'b1;
    expect_call(2, 1, 1'b0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hall_call_scheduler.md
# hall_call_scheduler

Latches hallway up/down call buttons and serialises pending calls one at a time into `building_dispatcher`. It presents `request_floor`/`request_dir` to the dispatcher and samples the resulting `dispatch_elev`. It then hands the call to the chosen car over a valid/ready handshake and clears the call once the car accepts it. The block sits directly upstream of `building_dispatcher` and between the hallway panels and the two car controllers.

## Interface
Parameters:
- `NUM_FLOORS`, 8, number of floors; must be ≤ 2**`FLOOR_W`
- `FLOOR_W`, 3, floor index width
- `WAIT_TIMEOUT`, 64, cycles an assignment may wait for ready before being withdrawn (≥ 2)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `hall_up_btn`  in  NUM_FLOORS  up-call buttons, level, bit i = floor i
- `hall_dn_btn`  in  NUM_FLOORS  down-call buttons, level
- `hall_up_lamp`  out  NUM_FLOORS  pending up calls (registered)
- `hall_dn_lamp`  out  NUM_FLOORS  pending down calls (registered)
- `request_floor`  out  FLOOR_W  to dispatcher, registered
- `request_dir`  out  1  to dispatcher, 1 = up, registered
- `dispatch_elev`  in  2  from dispatcher: 2'b10 = car 1, 2'b01 = car 2
- `assign_valid_1` / `assign_valid_2`  out  1  assignment offer to car 1 / car 2
- `assign_floor`  out  FLOOR_W  assigned floor, shared by both cars
- `assign_dir`  out  1  assigned direction, shared by both cars
- `assign_ready_1` / `assign_ready_2`  in  1  car accepts the assignment
- `busy`  out  1  FSM not in IDLE

## Operation
- Pending bits `up_pend` and `dn_pend`:
  - A button sets its bit on every cycle the button is high.
  - `hall_up_btn[NUM_FLOORS-1]` and `hall_dn_btn[0]` are ignored; those bits stay 0.
  - Lamps mirror the pending bits.
- Slot numbering: slot = {floor, dir}, giving 2·NUM_FLOORS slots scanned round-robin from `rr_ptr`, wrapping at the top.
- FSM states: IDLE, LOOKUP, ISSUE.
- IDLE:
  - If any pending bit is set, pick the first set slot at or after `rr_ptr`.
  - Register it into `request_floor`/`request_dir`/`assign_floor`/`assign_dir` and go to LOOKUP.
- LOOKUP (one cycle; the dispatcher is combinational):
  - Sample `dispatch_elev`.
  - 2'b10 → target = car 1. 2'b01 → target = car 2. Go to ISSUE.
  - 2'b00 or 2'b11 (illegal) → set `rr_ptr` = slot+1, return to IDLE, keep the pending bit.
- ISSUE:
  - Drive `assign_valid_<target>` high; the other valid stays low.
  - Floor and direction are held stable while valid is high.
  - Handshake = valid & ready on the same edge. On handshake: clear the slot's pending bit, set `rr_ptr` = slot+1, go to IDLE.
  - If `wait_cnt` reaches WAIT_TIMEOUT−1 with no handshake: drop valid, keep the pending bit, set `rr_ptr` = slot (re-dispatch the same call, which may now choose the other car), go to IDLE.
- Simultaneous events:
  - A button press for the slot being cleared on the handshake cycle: clear wins, because the car is already committed.
  - A press for any other slot is always captured.
  - Ready on the non-target car is ignored.
- Reset (including mid-ISSUE), effective the next cycle:
  - All pending bits, lamps, valids, `busy`, `wait_cnt`, `rr_ptr`, `request_*` and `assign_*` = 0.
  - FSM = IDLE.
  - The in-flight call is lost.

## Timing
- Button high at edge N → lamp high after edge N.
- IDLE selects at edge N+1 → `request_*` valid in cycle N+2.
- LOOKUP samples at edge N+2 → `assign_valid` high in cycle N+3.
- Ready high in cycle N+3 → lamp low and FSM in IDLE after edge N+3.
- Minimum call-to-call throughput: 3 cycles.
- `wait_cnt` resets to 0 on entry to ISSUE and increments each ISSUE cycle without a handshake.
- Timeout: valid is high for exactly WAIT_TIMEOUT cycles when ready never arrives.

## Structure
- Shared package `elevator_pkg` holds:
  - `NUM_FLOORS`, `FLOOR_W`
  - `DIR_UP` = 1'b1, `DIR_DN` = 1'b0
  - `DISPATCH_ELEV_1` = 2'b10, `DISPATCH_ELEV_2` = 2'b01
  - `sched_state_t` enum {IDLE, LOOKUP, ISSUE}
- One sub-module, `hall_call_picker`:
  - Combinational round-robin first-set finder over 2·NUM_FLOORS bits starting at `rr_ptr`.
  - Outputs `found` and `slot`.

## Test plan
- Reset check → after reset, all outputs are 0, `busy` = 0, and `hall_up_btn` = 8'hFF sets lamps to 8'h7F (floor 7 up ignored).
- Single call: up pulse at floor 3 with dispatcher returning 2'b10 → `request_floor` = 3 and `request_dir` = 1 in cycle N+2, `assign_valid_1` in N+3, `assign_ready_1` in N+3 → `hall_up_lamp[3]` clears after edge N+3.
- Round-robin order: floor 2 up, floor 5 down and floor 0 up pressed together → issued in slot order 0↑, 2↑, 5↓; a new 1↑ pressed after 2↑ is served after 5↓.
- Timeout and redirect: car 2 never readies with WAIT_TIMEOUT = 4 → valid_2 high for 4 cycles, call retained; re-dispatch gives 2'b10 → `assign_valid_1` asserts, then clears on handshake.
- Illegal dispatch: `dispatch_elev` = 2'b00 → no valid asserted, lamp stays on, FSM returns to IDLE and the next pending slot is tried.
- Edge cases, three separate checks:
  - Reset asserted mid-ISSUE → valid low and lamps cleared after the next edge.
  - Same-slot press on the handshake cycle → lamp clears.
  - Ready on the wrong car → ignored.
